sdram_init: RTL and testbench
=============================

SDRAM_INIT -- requirements
Module: sdram_init

Interface
REQ-001 SHALL have parameter T_POWER, default 20000, power-up wait in clk cycles (200 us at 100 MHz).
REQ-002 SHALL have parameter TRP_CLK, default 2, precharge-to-command wait in cycles.
REQ-003 SHALL have parameter TRC_CLK, default 7, auto-refresh-to-command wait in cycles.
REQ-004 SHALL have parameter TMRD_CLK, default 3, mode-register-set wait in cycles.
REQ-005 SHALL have parameter AR_NUM, default 8, number of auto-refresh commands.
REQ-006 SHALL have port clk  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-high (asserted when 1).
REQ-008 SHALL have port init_cmd  output  4  SDRAM command {cs_n, ras_n, cas_n, we_n}.
REQ-009 SHALL have port init_bank  output  2  bank address.
REQ-010 SHALL have port init_addr  output  13  row/mode address.
REQ-011 SHALL have port init_end  output  1  initialization complete, held high until reset.

Function
REQ-012 SHALL encode commands: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001, LOAD_MODE 4'b0000.
REQ-013 SHALL implement a Moore FSM with states IDLE, PRE, TRP, AR, TRF, MRS, TMRD, END; outputs decoded from the state register.
REQ-014 IDLE: NOP; a power counter increments every cycle from 0; at count T_POWER-1 go to PRE (IDLE lasts exactly T_POWER cycles).
REQ-015 PRE: one cycle, init_cmd PRECHARGE, init_bank 2'b11, init_addr 13'h1FFF (A10=1, all banks); then TRP.
REQ-016 TRP: NOP for TRP_CLK cycles; then AR.
REQ-017 AR: one cycle, AUTO_REFRESH, increments refresh counter; then TRF.
REQ-018 TRF: NOP for TRC_CLK cycles; then AR if fewer than AR_NUM refreshes issued, else MRS.
REQ-019 MRS: one cycle, LOAD_MODE, init_bank 2'b00, init_addr 13'b000_0_00_011_0_111 (write burst = programmed, CAS latency 3, sequential, full-page burst); then TMRD.
REQ-020 TMRD: NOP for TMRD_CLK cycles; then END.
REQ-021 END: NOP, init_end=1, terminal state until reset.
REQ-022 In all states except PRE and MRS, init_bank SHALL be 2'b11 and init_addr 13'h1FFF.
REQ-023 With defaults, relative to first clk edge after reset release as cycle 0: PRE at 20000, first AR at 20003, eighth AR at 20059, MRS at 20067, init_end high from 20071.
REQ-024 Wait counters SHALL clear on every state entry; widths SHALL cover T_POWER (15 bits min for default).

Reset
REQ-025 While rstn=1: state IDLE, all counters 0, init_cmd NOP, init_bank 2'b11, init_addr 13'h1FFF, init_end 0, immediately (asynchronous).
REQ-026 Reset asserted mid-sequence (any state) SHALL abort and restart the full sequence, including the T_POWER wait, after release.

Structure
REQ-027 Command encodings, state encodings, mode-register word and default timing constants SHALL live in shared package sdram_pkg (reused by refresh/read/write blocks).
REQ-028 A single sub-module sdram_wait_cnt (loadable cycle counter with done flag) MAY be used for TRP/TRC/TMRD waits; the power counter stays in sdram_init.

Verification
REQ-029 Reset released, defaults -> init_cmd NOP and init_end 0 for cycles 0..19999; PRECHARGE with bank 11, addr 1FFF at cycle 20000.
REQ-030 Full sequence -> exactly 8 AUTO_REFRESH commands spaced 8 cycles apart (20003..20059), NOP between.
REQ-031 MRS cycle 20067 -> init_cmd 0000, bank 00, addr 13'h0037; init_end rises at 20071 and stays high for 1000 further cycles.
REQ-032 Reset asserted at cycle 20030 (mid-refresh) for 3 cycles -> outputs return to reset values asynchronously; after release PRECHARGE again after 20000 cycles.
REQ-033 Parameters T_POWER=10, AR_NUM=2 -> PRE at 10, AR at 13 and 21, MRS at 29, init_end at 33.
REQ-034 Bench SHALL drive an SDRAM behavioural model (13-bit addr, 16-bit data, 9-bit column) on a phase-shifted 100 MHz clock and check it reports no protocol violations.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states, mode word and
// default timing, reused by the init, refresh, read and write controllers.
package sdram_pkg;

   localparam logic [3:0]  CMD_NOP          = 4'b0111;
   localparam logic [3:0]  CMD_PRECHARGE    = 4'b0010;
   localparam logic [3:0]  CMD_AUTO_REFRESH = 4'b0001;
   localparam logic [3:0]  CMD_LOAD_MODE    = 4'b0000;

   localparam logic [1:0]  BANK_ALL  = 2'b11;
   localparam logic [12:0] ADDR_ALL  = 13'h1FFF;
   localparam logic [1:0]  BANK_MODE = 2'b00;
   // Programmed write burst, CAS latency 3, sequential, full-page burst.
   localparam logic [12:0] MODE_WORD = 13'b000_0_00_011_0_111;

   localparam int unsigned T_POWER_DEF  = 20000;
   localparam int unsigned TRP_CLK_DEF  = 2;
   localparam int unsigned TRC_CLK_DEF  = 7;
   localparam int unsigned TMRD_CLK_DEF = 3;
   localparam int unsigned AR_NUM_DEF   = 8;
   localparam int unsigned WAIT_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_TRP,
      ST_AR,
      ST_TRF,
      ST_MRS,
      ST_TMRD,
      ST_END
   } init_state_e;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [1:0]  bank;
      logic [12:0] addr;
      logic        init_end;
   } init_out_t;

   function automatic init_out_t init_decode(input init_state_e st);
      init_out_t o;
      o.cmd      = CMD_NOP;
      o.bank     = BANK_ALL;
      o.addr     = ADDR_ALL;
      o.init_end = 1'b0;
      case (st)
         ST_PRE:  o.cmd = CMD_PRECHARGE;
         ST_AR:   o.cmd = CMD_AUTO_REFRESH;
         ST_MRS: begin
            o.cmd  = CMD_LOAD_MODE;
            o.bank = BANK_MODE;
            o.addr = MODE_WORD;
         end
         ST_END:  o.init_end = 1'b1;
         default: o.cmd = CMD_NOP;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Cycle counter for the short command-to-command waits; done_o flags the last
// cycle of a len_i-cycle wait. Held at zero while clr_i is high.
module sdram_wait_cnt
   import sdram_pkg::*;
#(
   parameter int unsigned W = WAIT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic [W-1:0] len_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr_i ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == len_i - 1'b1);

endmodule

// File: rtl/sdram_init.sv
// SDRAM power-up initialisation: power wait, precharge-all, AR_NUM auto
// refreshes, load mode register, then hold init_end until reset.
module sdram_init
   import sdram_pkg::*;
#(
   parameter int unsigned T_POWER  = T_POWER_DEF,
   parameter int unsigned TRP_CLK  = TRP_CLK_DEF,
   parameter int unsigned TRC_CLK  = TRC_CLK_DEF,
   parameter int unsigned TMRD_CLK = TMRD_CLK_DEF,
   parameter int unsigned AR_NUM   = AR_NUM_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [3:0]  init_cmd,
   output logic [1:0]  init_bank,
   output logic [12:0] init_addr,
   output logic        init_end,
   output init_state_e init_state
);

   localparam int unsigned PWR_W = (T_POWER > 1) ? $clog2(T_POWER) : 1;
   localparam int unsigned REF_W = $clog2(AR_NUM + 1);

   init_state_e       state_q, state_d;
   logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
   logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
   init_out_t         out_q;
   logic              wait_clr;
   logic [WAIT_W-1:0] wait_len;
   logic              wait_done;

   sdram_wait_cnt #(
      .W(WAIT_W)
   ) u_wait (
      .clk   (clk),
      .rst   (rstn),
      .clr_i (wait_clr),
      .len_i (wait_len),
      .done_o(wait_done)
   );

   // The wait counter is cleared in every non-wait state, so it always starts
   // from zero on entry to TRP, TRF and TMRD.
   always_comb begin
      state_d   = state_q;
      pwr_cnt_d = pwr_cnt_q;
      ref_cnt_d = ref_cnt_q;
      wait_clr  = 1'b1;
      wait_len  = WAIT_W'(TRP_CLK);
      case (state_q)
         ST_IDLE: begin
            if (pwr_cnt_q == PWR_W'(T_POWER - 1)) begin
               state_d = ST_PRE;
            end else begin
               pwr_cnt_d = pwr_cnt_q + 1'b1;
            end
         end
         ST_PRE: state_d = ST_TRP;
         ST_TRP: begin
            wait_clr = 1'b0;
            wait_len = WAIT_W'(TRP_CLK);
            if (wait_done) state_d = ST_AR;
         end
         ST_AR: begin
            ref_cnt_d = ref_cnt_q + 1'b1;
            state_d   = ST_TRF;
         end
         ST_TRF: begin
            wait_clr = 1'b0;
            wait_len = WAIT_W'(TRC_CLK);
            if (wait_done) begin
               state_d = (ref_cnt_q == REF_W'(AR_NUM)) ? ST_MRS : ST_AR;
            end
         end
         ST_MRS: state_d = ST_TMRD;
         ST_TMRD: begin
            wait_clr = 1'b0;
            wait_len = WAIT_W'(TMRD_CLK);
            if (wait_done) state_d = ST_END;
         end
         ST_END: state_d = ST_END;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q   <= ST_IDLE;
         pwr_cnt_q <= '0;
         ref_cnt_q <= '0;
         out_q     <= init_decode(ST_IDLE);
      end else begin
         state_q   <= state_d;
         pwr_cnt_q <= pwr_cnt_d;
         ref_cnt_q <= ref_cnt_d;
         out_q     <= init_decode(state_d);
      end
   end

   assign init_cmd   = out_q.cmd;
   assign init_bank  = out_q.bank;
   assign init_addr  = out_q.addr;
   assign init_end   = out_q.init_end;
   assign init_state = state_q;

endmodule

// File: tb/tb_sdram_init.sv
// Directed bench for sdram_init: default and short-parameter instances, a
// command-level SDRAM protocol model on a phase-shifted clock, and resets.
module tb_sdram_init;

  logic clk;
  logic clk_ps;
  logic rst;

  logic [3:0]  cmd_a, cmd_b;
  logic [1:0]  bank_a, bank_b;
  logic [12:0] addr_a, addr_b;
  logic        end_a, end_b;
  logic [2:0]  state_a, state_b;

  int n_vec = 0;
  int n_fail = 0;

  localparam logic [19:0] RESET_VEC = {4'b0111, 2'b11, 13'h1FFF, 1'b0};

  sdram_init u_dut_a (
    .clk       (clk),
    .rstn      (rst),
    .init_cmd  (cmd_a),
    .init_bank (bank_a),
    .init_addr (addr_a),
    .init_end  (end_a),
    .init_state(state_a)
  );

  sdram_init #(
    .T_POWER(10),
    .AR_NUM (2)
  ) u_dut_b (
    .clk       (clk),
    .rstn      (rst),
    .init_cmd  (cmd_b),
    .init_bank (bank_b),
    .init_addr (addr_b),
    .init_end  (end_b),
    .init_state(state_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_ps = 1'b0;
    #3;
    forever #5 clk_ps = ~clk_ps;
  end

  // SDRAM command-level model (13-bit row, 16-bit data, 9-bit column part)
  int          m_viol = 0;
  int          m_gap;
  int          m_ar;
  int          m_nops;
  logic        m_pre;
  logic        m_mode_ok;
  logic [3:0]  m_last;
  logic        m_bad;

  function automatic int min_gap(input logic [3:0] c);
    case (c)
      4'b0010: return 2;
      4'b0001: return 7;
      4'b0000: return 3;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    m_bad = 1'b0;
    if (cmd_a != 4'b0111 && (m_gap + 1) < min_gap(m_last)) m_bad = 1'b1;
    case (cmd_a)
      4'b0111: ;
      4'b0010: if (m_nops < 19999 || !addr_a[10]) m_bad = 1'b1;
      4'b0001: if (!m_pre) m_bad = 1'b1;
      4'b0000: if (m_ar < 2 || bank_a != 2'b00 || addr_a[12:7] != 6'd0 ||
                   !(addr_a[6:4] inside {3'd2, 3'd3})) m_bad = 1'b1;
      default: m_bad = 1'b1;
    endcase
  end

  always @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      m_gap     <= 1000;
      m_ar      <= 0;
      m_nops    <= 0;
      m_pre     <= 1'b0;
      m_mode_ok <= 1'b0;
      m_last    <= 4'b0111;
    end else begin
      if (m_bad) m_viol <= m_viol + 1;
      if (cmd_a == 4'b0111) begin
        m_gap <= m_gap + 1;
        if (!m_pre) m_nops <= m_nops + 1;
      end else begin
        m_gap  <= 0;
        m_last <= cmd_a;
      end
      if (cmd_a == 4'b0010) m_pre <= 1'b1;
      if (cmd_a == 4'b0001) m_ar <= m_ar + 1;
      if (cmd_a == 4'b0000)
        m_mode_ok <= (addr_a[6:4] == 3'd3) && !addr_a[3] && (addr_a[2:0] == 3'b111);
    end
  end

  // scoreboard helpers
  function automatic logic [19:0] exp_vec(input int n, input int pre_at, input int ar_cnt);
    int ar_first;
    int mrs_at;
    ar_first = pre_at + 3;
    mrs_at   = ar_first + 8 * ar_cnt;
    if (n == pre_at) return {4'b0010, 2'b11, 13'h1FFF, 1'b0};
    if (n >= ar_first && n < mrs_at && ((n - ar_first) % 8) == 0)
      return {4'b0001, 2'b11, 13'h1FFF, 1'b0};
    if (n == mrs_at) return {4'b0000, 2'b00, 13'h0037, 1'b0};
    if (n >= mrs_at + 4) return {4'b0111, 2'b11, 13'h1FFF, 1'b1};
    return {4'b0111, 2'b11, 13'h1FFF, 1'b0};
  endfunction

  task automatic check20(input string tag, input int n, input logic [19:0] obs,
                         input logic [19:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check20({tag, "_a"}, -1, {cmd_a, bank_a, addr_a, end_a}, RESET_VEC);
    check20({tag, "_b"}, -1, {cmd_b, bank_b, addr_b, end_b}, RESET_VEC);
    check_int({tag, "_state"}, int'(state_a), 0);
  endtask

  // cycle n is the value presented to the SDRAM at the n-th clk edge after release
  task automatic run_span(input int first, input int last);
    for (int n = first; n <= last; n++) begin
      check20("main", n, {cmd_a, bank_a, addr_a, end_a}, exp_vec(n, 20000, 8));
      check20("short", n, {cmd_b, bank_b, addr_b, end_b}, exp_vec(n, 10, 2));
      @(negedge clk);
    end
  endtask

  // directed steps
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst = 1'b0;

    run_span(0, 21071);
    check_int("model_violations_run1", m_viol, 0);
    check_int("model_refresh_count", m_ar, 8);
    check_int("model_mode_ok", int'(m_mode_ok), 1);
    check_int("end_state", int'(state_a), 7);

    #1 rst = 1'b1;
    #1 check_reset("async_from_end");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_span(0, 20029);
    check20("main", 20030, {cmd_a, bank_a, addr_a, end_a}, exp_vec(20030, 20000, 8));
    #1 rst = 1'b1;
    #1 check_reset("async_mid_refresh");
    repeat (3) begin
      @(negedge clk);
      check_reset("mid_reset_hold");
    end
    rst = 1'b0;

    run_span(0, 20003);
    check_int("model_violations_run2", m_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
